// File: rtl/fetch_bundle_queue.sv
// fetch_bundle_queue
//   Fetch stage that sits behind the program counter. It issues at most one
//   bundle fetch per cycle, holds in-order memory responses in a DEPTH-entry
//   queue, and hands each bundle to decode as two instructions with the
//   bundle PC. A redirect flushes the queue and drops responses that are
//   still in flight for the old path.
//
// Ports
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   pc, redirect        : current PC; jump/branch taken this cycle
//   pc_advance          : fetch request accepted, PC stage may step by 120
//   imem_req_*          : fetch request handshake and address (= pc)
//   imem_rsp_*          : in-order response bundle from instruction memory
//   dec_valid/ready     : head bundle handshake toward decode
//   dec_instr0/1, dec_pc: head bundle split into upper/lower instruction
//   err_unexpected_rsp  : sticky, a response arrived with nothing outstanding
module fetch_bundle_queue #(
  parameter int PC_W    = 72,
  parameter int INSTR_W = 60,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_W-1:0]      pc,
  input  logic                 redirect,
  output logic                 pc_advance,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [PC_W-1:0]      imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [2*INSTR_W-1:0] imem_rsp_data,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [INSTR_W-1:0]   dec_instr0,
  output logic [INSTR_W-1:0]   dec_instr1,
  output logic [PC_W-1:0]      dec_pc,
  output logic                 err_unexpected_rsp
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = 2 * INSTR_W;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  // Circular pointer step; explicit wrap keeps non-power-of-two depths legal.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  logic [0:0]    state;
  logic [CW-1:0] occ;
  logic [CW-1:0] outst;
  logic [CW-1:0] discard;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] pc_wr;
  logic [PW-1:0] pc_rd;
  logic          err;

  logic [PC_W-1:0] pcq [DEPTH];
  logic [BW-1:0]   bq  [DEPTH];
  logic [PC_W-1:0] bpc [DEPTH];

  logic [CW:0]   fill;
  logic          accept;
  logic          rsp_ok;
  logic          rsp_spur;
  logic          push;
  logic          pop;
  logic [CW-1:0] discard_nxt;

  // Request side: queued bundles plus in-flight requests form the credit.
  assign fill           = {1'b0, occ} + {1'b0, outst};
  assign imem_req_valid = !reset && (state == RUN) && !redirect &&
                          (fill < (CW + 1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_advance     = accept;

  // Response side: only responses matching an outstanding request count.
  assign rsp_ok      = imem_rsp_valid && (outst != '0);
  assign rsp_spur    = imem_rsp_valid && (outst == '0);
  assign push        = rsp_ok && (state == RUN) && !redirect;
  assign pop         = dec_valid && dec_ready;
  // A same-cycle response is part of the stale set and is dropped here.
  assign discard_nxt = outst - CW'(rsp_ok);

  // Decode side: head of the registered queue, no bypass.
  assign dec_valid          = (occ != '0);
  assign dec_instr0         = bq[head][BW-1:INSTR_W];
  assign dec_instr1         = bq[head][INSTR_W-1:0];
  assign dec_pc             = bpc[head];
  assign err_unexpected_rsp = err;

  // ---- storage stage: request PCs and buffered bundles (data, no reset)
  always_ff @(posedge clk) begin
    if (accept) pcq[pc_wr] <= pc;
    if (push) begin
      bq[tail]  <= imem_rsp_data;
      bpc[tail] <= pcq[pc_rd];
    end
  end

  // ---- control stage: counters, pointers, state
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      occ     <= '0;
      outst   <= '0;
      discard <= '0;
      head    <= '0;
      tail    <= '0;
      pc_wr   <= '0;
      pc_rd   <= '0;
      err     <= 1'b0;
    end else begin
      outst <= outst + CW'(accept) - CW'(rsp_ok);
      // The PC FIFO tracks every outstanding request, stale or not, so it is
      // never flushed: dropped responses still retire their PC entry.
      if (accept) pc_wr <= ptr_inc(pc_wr);
      if (rsp_ok) pc_rd <= ptr_inc(pc_rd);
      if (rsp_spur) err <= 1'b1;
      if (redirect) begin
        occ     <= '0;
        head    <= '0;
        tail    <= '0;
        discard <= discard_nxt;
        state   <= (discard_nxt != '0) ? DRAIN : RUN;
      end else begin
        if (push) tail <= ptr_inc(tail);
        if (pop)  head <= ptr_inc(head);
        occ <= occ + CW'(push) - CW'(pop);
        if ((state == DRAIN) && rsp_ok) begin
          discard <= discard - CW'(1);
          if (discard == CW'(1)) state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_bundle_queue.sv
module tb_fetch_bundle_queue;

  localparam int PC_W    = 72;
  localparam int INSTR_W = 60;
  localparam int DEPTH   = 4;
  localparam int BW      = 2 * INSTR_W;

  logic               clk = 1'b0;
  logic               reset;
  logic [PC_W-1:0]    pc;
  logic               redirect;
  logic               pc_advance;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [BW-1:0]      imem_rsp_data;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr0;
  logic [INSTR_W-1:0] dec_instr1;
  logic [PC_W-1:0]    dec_pc;
  logic               err_unexpected_rsp;

  fetch_bundle_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc(pc), .redirect(redirect),
    .pc_advance(pc_advance), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr0(dec_instr0),
    .dec_instr1(dec_instr1), .dec_pc(dec_pc),
    .err_unexpected_rsp(err_unexpected_rsp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [BW-1:0]   data;
  } exp_t;

  exp_t            exp_q [$];
  logic [PC_W-1:0] pend_q [$];

  int   total = 0;
  int   bad   = 0;
  logic hold_mem, spur;
  logic s_req_valid, s_adv;
  int   nacc;

  task automatic chk_val(input string tag, input logic [127:0] got,
                         input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [BW-1:0] mkdata(input logic [PC_W-1:0] a);
    logic [BW-1:0] d;
    d[BW-1:INSTR_W]  = a[INSTR_W-1:0] ^ 60'hA5A_5A5A_0F0F_F0F0;
    d[INSTR_W-1:0]   = a[INSTR_W-1:0] + 60'h123_4567_89AB_CDEF;
    return d;
  endfunction

  // One clock cycle: inputs are driven after the falling edge, outputs are
  // sampled 1 time unit later, then the rising edge commits.
  task automatic cycle();
    exp_t          e;
    logic [BW-1:0] d;
    if (spur) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = {BW{1'b1}};
    end else if (!hold_mem && pend_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mkdata(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_adv       = pc_advance;
    if (reset) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (dec_valid && dec_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          chk_val("extra_out", dec_pc, '1);
        end else begin
          e = exp_q.pop_front();
          d = e.data;
          chk_val("dec_pc", dec_pc, e.pc);
          chk_val("dec_instr0", dec_instr0, d[BW-1:INSTR_W]);
          chk_val("dec_instr1", dec_instr1, d[INSTR_W-1:0]);
        end
      end
      if (redirect) exp_q.delete();
      if (pc_advance) begin
        pend_q.push_back(imem_req_addr);
        e.pc   = pc;
        e.data = mkdata(pc);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    if (!reset && s_adv) pc = pc + PC_W'(120);
  endtask

  task automatic run(input int n);
    nacc = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (s_adv) nacc++;
    end
  endtask

  initial begin
    reset = 1'b1; pc = '0; redirect = 1'b0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;
    hold_mem = 1'b0; spur = 1'b0;
    @(negedge clk);

    // reset
    cycle();
    chk_val("rst_req_valid", s_req_valid, 0);
    chk_val("rst_adv", s_adv, 0);
    cycle();
    reset = 1'b0;
    chk_val("rst_dec_valid", dec_valid, 0);
    chk_val("rst_err", err_unexpected_rsp, 0);
    chk_val("rst_state", dut.state, 0);

    // streaming
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk_val("stream_adv", s_adv, 1);
    end
    run(4);

    // backpressure from decode
    imem_req_ready = 1'b0; run(4);
    dec_ready = 1'b0; imem_req_ready = 1'b1;
    run(10);
    chk_val("bp_accepts", nacc, DEPTH);
    chk_val("bp_req_valid", s_req_valid, 0);
    dec_ready = 1'b1;
    run(12);

    // redirect with 3 in flight and 1 buffered
    imem_req_ready = 1'b0; run(4);
    hold_mem = 1'b1; dec_ready = 1'b0; imem_req_ready = 1'b1;
    run(4);
    chk_val("fill_accepts", nacc, DEPTH);
    imem_req_ready = 1'b0; hold_mem = 1'b0;
    run(1);
    hold_mem = 1'b1; redirect = 1'b1; pc = 72'h500;
    run(1);
    redirect = 1'b0;
    chk_val("redir_dec_valid", dec_valid, 0);
    chk_val("redir_state", dut.state, 1);
    chk_val("redir_discard", dut.discard, 3);
    hold_mem = 1'b0; dec_ready = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_val("drain_req_valid", s_req_valid, 0);
    end
    cycle();
    chk_val("resume_req_valid", s_req_valid, 1);
    chk_val("resume_state", dut.state, 0);
    run(6);

    // redirect coincident with response and pop, one outstanding
    imem_req_ready = 1'b0; run(4);
    dec_ready = 1'b0; hold_mem = 1'b1; imem_req_ready = 1'b1; run(1);
    imem_req_ready = 1'b0; hold_mem = 1'b0; run(1);
    hold_mem = 1'b1; imem_req_ready = 1'b1; run(1);
    imem_req_ready = 1'b0; hold_mem = 1'b0; dec_ready = 1'b1;
    redirect = 1'b1; pc = 72'hA00;
    run(1);
    redirect = 1'b0;
    chk_val("coinc_state", dut.state, 0);
    chk_val("coinc_discard", dut.discard, 0);
    chk_val("coinc_outst", dut.outst, 0);
    chk_val("coinc_dec_valid", dec_valid, 0);
    run(3);
    chk_val("coinc_quiet", dec_valid, 0);
    imem_req_ready = 1'b1; run(6);

    // spurious response while idle
    imem_req_ready = 1'b0; run(4);
    spur = 1'b1; run(1); spur = 1'b0;
    chk_val("spur_err", err_unexpected_rsp, 1);
    chk_val("spur_dec_valid", dec_valid, 0);
    run(3);
    chk_val("spur_err_sticky", err_unexpected_rsp, 1);
    chk_val("spur_queue_empty", dec_valid, 0);

    // reset in the middle of a drain
    hold_mem = 1'b1; imem_req_ready = 1'b1; run(2);
    imem_req_ready = 1'b0; redirect = 1'b1; pc = 72'hC00; run(1);
    redirect = 1'b0;
    chk_val("mid_state", dut.state, 1);
    chk_val("mid_discard", dut.discard, 2);
    reset = 1'b1; run(1); reset = 1'b0;
    chk_val("mrst_state", dut.state, 0);
    chk_val("mrst_discard", dut.discard, 0);
    chk_val("mrst_outst", dut.outst, 0);
    chk_val("mrst_occ", dut.occ, 0);
    chk_val("mrst_err", err_unexpected_rsp, 0);
    hold_mem = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
    cycle();
    chk_val("mrst_resume_adv", s_adv, 1);
    run(6);

    imem_req_ready = 1'b0; run(5);
    chk_val("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
